// File: rtl/mt_xport_pkg.sv
// mt_xport_pkg
// Shared definitions for the MT tape transport sequencer: drive function
// codes as they appear in CS1[5:1], the sequencer state encoding and a
// helper that classifies function codes the transport acts on.
package mt_xport_pkg;

  localparam logic [4:0] FN_NOP    = 5'd0;
  localparam logic [4:0] FN_UNLOAD = 5'd1;
  localparam logic [4:0] FN_REWIND = 5'd3;
  localparam logic [4:0] FN_DRVCLR = 5'd4;
  localparam logic [4:0] FN_ERASE  = 5'd10;
  localparam logic [4:0] FN_WRTM   = 5'd11;
  localparam logic [4:0] FN_SPCFWD = 5'd12;
  localparam logic [4:0] FN_SPCREV = 5'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_MOVE,
    ST_SLOW,
    ST_DONE,
    ST_RWND
  } state_t;

  // Codes outside this set are dropped without touching any drive state.
  function automatic logic fn_known(input logic [4:0] fn);
    return fn inside {FN_NOP, FN_UNLOAD, FN_REWIND, FN_DRVCLR,
                      FN_ERASE, FN_WRTM, FN_SPCFWD, FN_SPCREV};
  endfunction

endpackage

// File: rtl/mt_xport_timer.sv
// mt_xport_timer
// Loadable down counter used to time acceleration, per-record, slow-down
// and rewind periods. Loading a period P makes tc high on the last of the
// next P cycles; with no reload the count parks at zero with tc held high.
//   clk, rst : clock, synchronous active-high reset
//   load     : load a new period this cycle
//   period   : period length in cycles (must be >= 1)
//   tc       : terminal count, last cycle of the current period
module mt_xport_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] period,
  output logic         tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period - ONE;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mt_xport_seq.sv
// mt_xport_seq
// Tape transport motion sequencer for the TM03/TU45 emulation. Executes
// space, write tape mark, erase, rewind, unload and drive clear, keeps the
// tape position as a record counter and produces the raw drive status
// strobes consumed by the drive status register.
//   clk, rst          : clock, synchronous active-high reset
//   mtINIT            : controller init, aborts any motion
//   mtGO, mtFUN       : function strobe and function code
//   mtFC              : frame count (two's complement record count)
//   mtMOLIN, mtTMREC  : media present, tape mark at current record
//   mtDRY/PIP/SDWN    : ready, positioning, slowing-down levels
//   mtATA/SETIDB/CLRIDB/FCINC/UNLD : one-cycle pulses
//   mtTM/BOT/EOT      : tape mark, beginning / end of tape levels
//   mtPOS             : current record position
module mt_xport_seq
  import mt_xport_pkg::*;
#(
  parameter int unsigned ACCEL_CYC = 8,
  parameter int unsigned REC_CYC   = 16,
  parameter int unsigned SLOW_CYC  = 8,
  parameter int unsigned RWD_CYC   = 2,
  parameter logic [15:0] EOT_POS   = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtINIT,
  input  logic        mtGO,
  input  logic [4:0]  mtFUN,
  input  logic [15:0] mtFC,
  input  logic        mtMOLIN,
  input  logic        mtTMREC,
  output logic        mtDRY,
  output logic        mtPIP,
  output logic        mtSDWN,
  output logic        mtATA,
  output logic        mtSETIDB,
  output logic        mtCLRIDB,
  output logic        mtTM,
  output logic        mtBOT,
  output logic        mtEOT,
  output logic        mtFCINC,
  output logic        mtUNLD,
  output logic [15:0] mtPOS
);

  localparam logic [15:0] ACCEL_P = 16'(ACCEL_CYC);
  localparam logic [15:0] REC_P   = 16'(REC_CYC);
  localparam logic [15:0] SLOW_P  = 16'(SLOW_CYC);
  localparam logic [15:0] RWD_P   = 16'(RWD_CYC);

  // Position moves forward saturating at the end of the counter range and
  // backward flooring at BOT.
  function automatic logic [15:0] pos_inc(input logic [15:0] p);
    return (p == 16'hFFFF) ? p : p + 16'd1;
  endfunction

  function automatic logic [15:0] pos_dec(input logic [15:0] p);
    return (p == 16'd0) ? p : p - 16'd1;
  endfunction

  state_t      state;
  logic [4:0]  fun;
  logic [15:0] pos;

  logic        tc;
  logic        tmr_load;
  logic [15:0] tmr_period;
  logic        go_ok;
  logic        is_space;
  logic        rec_stop;
  logic [15:0] pos_nxt;

  // INIT in the same cycle as GO wins, so GO is simply not accepted.
  assign go_ok    = mtGO && !mtINIT && mtMOLIN && (state == ST_IDLE) && fn_known(mtFUN);
  assign is_space = (fun == FN_SPCFWD) || (fun == FN_SPCREV);

  // Evaluated on the record-pass cycle. WRTM/ERASE always stop after one
  // record; a space stops on a tape mark, on the record that takes the
  // frame count to zero, or when a reverse space reaches BOT.
  assign rec_stop = !is_space || mtTMREC || (mtFC == 16'hFFFF)
                    || ((fun == FN_SPCREV) && (pos <= 16'd1));

  assign pos_nxt = ((state == ST_RWND) || (fun == FN_SPCREV)) ? pos_dec(pos) : pos_inc(pos);

  // Timer reload points. A redundant load on a transition out of a timed
  // state is harmless since the next state either reloads or ignores tc.
  always_comb begin
    tmr_load   = 1'b0;
    tmr_period = REC_P;
    case (state)
      ST_IDLE: begin
        tmr_load   = go_ok;
        tmr_period = ((mtFUN == FN_REWIND) || (mtFUN == FN_UNLOAD)) ? RWD_P : ACCEL_P;
      end
      ST_ACCEL: begin
        tmr_load   = tc;
        tmr_period = REC_P;
      end
      ST_MOVE: begin
        tmr_load   = tc;
        tmr_period = rec_stop ? SLOW_P : REC_P;
      end
      ST_RWND: begin
        tmr_load   = tc;
        tmr_period = RWD_P;
      end
      default: begin
        tmr_load   = 1'b0;
        tmr_period = REC_P;
      end
    endcase
  end

  mt_xport_timer #(.W(16)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .period (tmr_period),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fun      <= FN_NOP;
      pos      <= 16'd0;
      mtDRY    <= 1'b1;
      mtPIP    <= 1'b0;
      mtSDWN   <= 1'b0;
      mtATA    <= 1'b0;
      mtSETIDB <= 1'b0;
      mtCLRIDB <= 1'b0;
      mtTM     <= 1'b0;
      mtBOT    <= 1'b1;
      mtEOT    <= 1'b0;
      mtFCINC  <= 1'b0;
      mtUNLD   <= 1'b0;
    end else begin
      mtATA    <= 1'b0;
      mtSETIDB <= 1'b0;
      mtCLRIDB <= 1'b0;
      mtFCINC  <= 1'b0;
      mtUNLD   <= 1'b0;
      if (mtINIT) begin
        state  <= ST_IDLE;
        mtDRY  <= 1'b1;
        mtPIP  <= 1'b0;
        mtSDWN <= 1'b0;
        mtTM   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (go_ok) begin
              fun      <= mtFUN;
              mtCLRIDB <= 1'b1;
              mtTM     <= 1'b0;
              case (mtFUN)
                FN_REWIND, FN_UNLOAD: begin
                  state <= ST_RWND;
                  mtPIP <= 1'b1;
                end
                FN_ERASE, FN_WRTM, FN_SPCFWD: begin
                  state <= ST_ACCEL;
                  mtDRY <= 1'b0;
                end
                FN_SPCREV: begin
                  if (pos == 16'd0) begin
                    state <= ST_DONE;
                    mtATA <= 1'b1;
                  end else begin
                    state <= ST_ACCEL;
                    mtDRY <= 1'b0;
                  end
                end
                default: state <= ST_IDLE;
              endcase
            end
          end

          ST_ACCEL: begin
            if (!mtMOLIN) begin
              state <= ST_DONE;
              mtDRY <= 1'b1;
              mtATA <= 1'b1;
            end else if (tc) begin
              state <= ST_MOVE;
            end
          end

          // Record boundary: position, BOT/EOT and record pulses move together.
          ST_MOVE: begin
            if (!mtMOLIN) begin
              state <= ST_DONE;
              mtDRY <= 1'b1;
              mtATA <= 1'b1;
            end else if (tc) begin
              pos     <= pos_nxt;
              mtBOT   <= (pos_nxt == 16'd0);
              mtEOT   <= (pos_nxt >= EOT_POS);
              mtFCINC <= 1'b1;
              if ((fun == FN_SPCFWD) && (pos == 16'd0)) mtSETIDB <= 1'b1;
              if ((fun == FN_WRTM) || (is_space && mtTMREC)) mtTM <= 1'b1;
              if (rec_stop) begin
                state  <= ST_SLOW;
                mtSDWN <= 1'b1;
              end
            end
          end

          ST_SLOW: begin
            if (!mtMOLIN || tc) begin
              state  <= ST_DONE;
              mtSDWN <= 1'b0;
              mtDRY  <= 1'b1;
              mtATA  <= 1'b1;
            end
          end

          // Rewind/unload: position counts down at the fast rewind rate.
          ST_RWND: begin
            if (!mtMOLIN) begin
              state <= ST_DONE;
              mtPIP <= 1'b0;
              mtATA <= 1'b1;
            end else if (pos == 16'd0) begin
              state  <= ST_DONE;
              mtPIP  <= 1'b0;
              mtATA  <= 1'b1;
              mtUNLD <= (fun == FN_UNLOAD);
            end else if (tc) begin
              pos   <= pos_nxt;
              mtBOT <= (pos_nxt == 16'd0);
              mtEOT <= (pos_nxt >= EOT_POS);
              if (pos == 16'd1) begin
                state  <= ST_DONE;
                mtPIP  <= 1'b0;
                mtATA  <= 1'b1;
                mtUNLD <= (fun == FN_UNLOAD);
              end
            end
          end

          ST_DONE: state <= ST_IDLE;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mtPOS = pos;

endmodule

// File: tb/tb_mt_xport_seq.sv
// tb_mt_xport_seq
// Scoreboard bench for mt_xport_seq: each issued function pushes its
// expected outcome, which is popped and compared when the attention pulse
// arrives. The bench also emulates the frame-count register (incremented
// on mtFCINC) and a media model that flags a tape mark at a chosen record.
module tb_mt_xport_seq;

  localparam int ACC = 8;
  localparam int REC = 16;
  localparam int SLW = 8;
  localparam int RWD = 2;
  localparam logic [15:0] EOT = 16'd6;

  localparam logic [4:0] F_NOP    = 5'd0;
  localparam logic [4:0] F_UNLOAD = 5'd1;
  localparam logic [4:0] F_REWIND = 5'd3;
  localparam logic [4:0] F_DRVCLR = 5'd4;
  localparam logic [4:0] F_ERASE  = 5'd10;
  localparam logic [4:0] F_WRTM   = 5'd11;
  localparam logic [4:0] F_SPCFWD = 5'd12;
  localparam logic [4:0] F_SPCREV = 5'd13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mtINIT = 1'b0;
  logic        mtGO = 1'b0;
  logic [4:0]  mtFUN = 5'd0;
  logic [15:0] mtFC;
  logic        mtMOLIN = 1'b1;
  logic        mtTMREC;
  logic        mtDRY, mtPIP, mtSDWN, mtATA, mtSETIDB, mtCLRIDB;
  logic        mtTM, mtBOT, mtEOT, mtFCINC, mtUNLD;
  logic [15:0] mtPOS;

  mt_xport_seq #(
    .ACCEL_CYC (ACC),
    .REC_CYC   (REC),
    .SLOW_CYC  (SLW),
    .RWD_CYC   (RWD),
    .EOT_POS   (EOT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mtINIT   (mtINIT),
    .mtGO     (mtGO),
    .mtFUN    (mtFUN),
    .mtFC     (mtFC),
    .mtMOLIN  (mtMOLIN),
    .mtTMREC  (mtTMREC),
    .mtDRY    (mtDRY),
    .mtPIP    (mtPIP),
    .mtSDWN   (mtSDWN),
    .mtATA    (mtATA),
    .mtSETIDB (mtSETIDB),
    .mtCLRIDB (mtCLRIDB),
    .mtTM     (mtTM),
    .mtBOT    (mtBOT),
    .mtEOT    (mtEOT),
    .mtFCINC  (mtFCINC),
    .mtUNLD   (mtUNLD),
    .mtPOS    (mtPOS)
  );

  always #5 clk = ~clk;

  // Cycle counter and per-signal activity counters, sampled mid-cycle.
  int cyc = 0;
  int n_drylow = 0, n_pip = 0, n_sdwn = 0, n_fcinc = 0;
  int n_setidb = 0, n_clridb = 0, n_ata = 0, n_unld = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mtDRY !== 1'b1)   n_drylow <= n_drylow + 1;
    if (mtPIP === 1'b1)   n_pip    <= n_pip + 1;
    if (mtSDWN === 1'b1)  n_sdwn   <= n_sdwn + 1;
    if (mtFCINC === 1'b1) n_fcinc  <= n_fcinc + 1;
    if (mtSETIDB === 1'b1) n_setidb <= n_setidb + 1;
    if (mtCLRIDB === 1'b1) n_clridb <= n_clridb + 1;
    if (mtATA === 1'b1)   n_ata    <= n_ata + 1;
    if (mtUNLD === 1'b1)  n_unld   <= n_unld + 1;
  end

  // Frame-count register emulation and media tape-mark model. The record
  // crossed when leaving position p forward is record p+1.
  logic [15:0] fc_base = 16'd0;
  int          fc_snap = 0;
  logic        tm_en = 1'b0;
  logic [15:0] tm_pos = 16'd0;

  assign mtFC    = fc_base + 16'(n_fcinc - fc_snap);
  assign mtTMREC = tm_en && (mtPOS == tm_pos);

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          lat;
    int          drylow;
    int          pip;
    int          sdwn;
    int          fcinc;
    int          setidb;
    int          unld;
    logic [15:0] pos;
    logic        tm;
  } exp_t;

  exp_t sb[$];

  int go_cyc = 0;
  int s_drylow, s_pip, s_sdwn, s_fcinc, s_setidb, s_clridb, s_ata, s_unld;

  task automatic snap();
    s_drylow = n_drylow; s_pip = n_pip; s_sdwn = n_sdwn; s_fcinc = n_fcinc;
    s_setidb = n_setidb; s_clridb = n_clridb; s_ata = n_ata; s_unld = n_unld;
  endtask

  task automatic issue(input logic [4:0] fn, input logic [15:0] fc);
    @(posedge clk); #1;
    fc_base = fc;
    fc_snap = n_fcinc;
    snap();
    go_cyc = cyc;
    mtFUN = fn;
    mtGO = 1'b1;
    @(posedge clk); #1;
    mtGO = 1'b0;
  endtask

  task automatic pulse_go(input logic [4:0] fn);
    mtFUN = fn;
    mtGO = 1'b1;
    @(posedge clk); #1;
    mtGO = 1'b0;
  endtask

  // Reference model of a space/write/erase: walks records from p0 and
  // reports record count, final position and whether a tape mark stopped it.
  task automatic model_space(input bit rev, input logic [15:0] p0, input logic [15:0] f0,
                             input bit ten, input logic [15:0] tp,
                             output int n, output logic [15:0] pe, output bit tmh);
    logic [15:0] p, f;
    bit hit, last;
    p = p0; f = f0; n = 0; tmh = 0;
    for (int i = 0; i < 70000; i++) begin
      hit  = ten && (p == tp);
      last = (f == 16'hFFFF);
      p    = rev ? p - 16'd1 : ((p == 16'hFFFF) ? p : p + 16'd1);
      f    = f + 16'd1;
      n++;
      if (hit) tmh = 1;
      if (hit || last || (rev && p == 16'd0)) break;
    end
    pe = p;
  endtask

  task automatic push_space(input string tag, input bit rev, input logic [15:0] fc,
                            input logic [15:0] start, input bit single, input bit wrtm);
    exp_t e;
    int n;
    logic [15:0] pe;
    bit tmh;
    if (single) begin
      n = 1; pe = start + 16'd1; tmh = 0;
    end else begin
      model_space(rev, start, fc, tm_en, tm_pos, n, pe, tmh);
    end
    e.tag    = tag;
    e.drylow = ACC + n * REC + SLW;
    e.lat    = e.drylow + 1;
    e.pip    = 0;
    e.sdwn   = SLW;
    e.fcinc  = n;
    e.setidb = (!rev && !single && start == 16'd0) ? 1 : 0;
    e.unld   = 0;
    e.pos    = pe;
    e.tm     = tmh || wrtm;
    sb.push_back(e);
  endtask

  task automatic push_rwd(input string tag, input logic [15:0] p, input bit unload);
    exp_t e;
    e.tag    = tag;
    e.lat    = int'(p) * RWD + 1;
    e.drylow = 0;
    e.pip    = int'(p) * RWD;
    e.sdwn   = 0;
    e.fcinc  = 0;
    e.setidb = 0;
    e.unld   = unload ? 1 : 0;
    e.pos    = 16'd0;
    e.tm     = 1'b0;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the attention pulse, then scores the oldest
  // expectation against what the DUT did since the GO.
  task automatic finish_op(input int budget);
    exp_t e;
    bit seen;
    int lat;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mtATA === 1'b1) begin
        seen = 1;
        break;
      end
    end
    lat = cyc - go_cyc;
    @(posedge clk); #1;
    e = sb.pop_front();
    check_val({e.tag, "_ata_seen"}, 32'(seen), 32'd1);
    if (e.lat >= 0)    check_val({e.tag, "_ata_latency"}, lat, e.lat);
    if (e.drylow >= 0) check_val({e.tag, "_dry_low"}, n_drylow - s_drylow, e.drylow);
    check_val({e.tag, "_ata_count"}, n_ata - s_ata, 1);
    check_val({e.tag, "_clridb"}, n_clridb - s_clridb, 1);
    check_val({e.tag, "_pip"}, n_pip - s_pip, e.pip);
    check_val({e.tag, "_sdwn"}, n_sdwn - s_sdwn, e.sdwn);
    check_val({e.tag, "_fcinc"}, n_fcinc - s_fcinc, e.fcinc);
    check_val({e.tag, "_setidb"}, n_setidb - s_setidb, e.setidb);
    check_val({e.tag, "_unld"}, n_unld - s_unld, e.unld);
    check_val({e.tag, "_pos"}, mtPOS, e.pos);
    check_val({e.tag, "_tm"}, mtTM, e.tm);
    check_val({e.tag, "_bot"}, mtBOT, (e.pos == 16'd0));
    check_val({e.tag, "_eot"}, mtEOT, (e.pos >= EOT));
    check_val({e.tag, "_dry"}, mtDRY, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_val("reset_dry", mtDRY, 1'b1);
    check_val("reset_bot", mtBOT, 1'b1);
    check_val("reset_pos", mtPOS, 16'd0);
    check_val("reset_levels", {mtPIP, mtSDWN, mtTM, mtEOT}, 4'b0000);
    check_val("reset_pulses", {mtATA, mtSETIDB, mtCLRIDB, mtFCINC, mtUNLD}, 5'b00000);

    // Forward space 3 records from BOT; a GO while busy must be ignored.
    push_space("spc3", 1'b0, 16'hFFFD, mtPOS, 1'b0, 1'b0);
    issue(F_SPCFWD, 16'hFFFD);
    repeat (20) @(posedge clk); #1;
    pulse_go(F_REWIND);
    finish_op(200);

    // Forward 3 more, reaching the EOT position.
    push_space("spc_eot", 1'b0, 16'hFFFD, mtPOS, 1'b0, 1'b0);
    issue(F_SPCFWD, 16'hFFFD);
    finish_op(200);

    push_rwd("rewind", mtPOS, 1'b0);
    issue(F_REWIND, 16'd0);
    finish_op(100);

    // Tape mark at record 2: forward space stops there despite a large count.
    tm_en = 1'b1;
    tm_pos = 16'd1;
    push_space("spc_tm", 1'b0, 16'hFFF0, mtPOS, 1'b0, 1'b0);
    issue(F_SPCFWD, 16'hFFF0);
    finish_op(300);
    tm_en = 1'b0;

    // Reverse space stops at BOT.
    push_space("spcrev_bot", 1'b1, 16'hFFF0, mtPOS, 1'b0, 1'b0);
    issue(F_SPCREV, 16'hFFF0);
    finish_op(300);

    // Reverse space issued at BOT: attention with no motion.
    begin
      exp_t e;
      e.tag = "spcrev_at_bot"; e.lat = 1; e.drylow = 0; e.pip = 0; e.sdwn = 0;
      e.fcinc = 0; e.setidb = 0; e.unld = 0; e.pos = 16'd0; e.tm = 1'b0;
      sb.push_back(e);
    end
    issue(F_SPCREV, 16'hFFFF);
    finish_op(20);

    push_space("wrtm", 1'b0, 16'd0, mtPOS, 1'b1, 1'b1);
    issue(F_WRTM, 16'd0);
    finish_op(200);

    // Drive clear: accepted (CLRIDB, TM cleared) but no motion, no attention.
    issue(F_DRVCLR, 16'd0);
    repeat (5) @(posedge clk); #1;
    check_val("drvclr_clridb", n_clridb - s_clridb, 1);
    check_val("drvclr_tm", mtTM, 1'b0);
    check_val("drvclr_ata", n_ata - s_ata, 0);
    check_val("drvclr_dry_low", n_drylow - s_drylow, 0);

    push_space("erase", 1'b0, 16'd0, mtPOS, 1'b1, 1'b0);
    issue(F_ERASE, 16'd0);
    finish_op(200);

    push_rwd("unload", mtPOS, 1'b1);
    issue(F_UNLOAD, 16'd0);
    finish_op(100);

    // GO without media is ignored.
    mtMOLIN = 1'b0;
    issue(F_SPCFWD, 16'hFFFF);
    repeat (5) @(posedge clk); #1;
    check_val("nomol_clridb", n_clridb - s_clridb, 0);
    check_val("nomol_dry_low", n_drylow - s_drylow, 0);
    mtMOLIN = 1'b1;

    // INIT in the same cycle as GO drops the GO.
    @(posedge clk); #1;
    snap();
    mtINIT = 1'b1;
    pulse_go(F_SPCFWD);
    mtINIT = 1'b0;
    repeat (5) @(posedge clk); #1;
    check_val("init_go_clridb", n_clridb - s_clridb, 0);
    check_val("init_go_dry_low", n_drylow - s_drylow, 0);

    // INIT during acceleration/motion aborts to idle without attention.
    issue(F_SPCFWD, 16'hFFF0);
    repeat (12) @(posedge clk); #1;
    check_val("init_pre_dry", mtDRY, 1'b0);
    mtINIT = 1'b1;
    @(posedge clk); #1;
    mtINIT = 1'b0;
    check_val("init_dry", mtDRY, 1'b1);
    check_val("init_sdwn", mtSDWN, 1'b0);
    check_val("init_pip", mtPIP, 1'b0);
    repeat (60) @(posedge clk); #1;
    check_val("init_no_ata", n_ata - s_ata, 0);
    check_val("init_pos", mtPOS, 16'd0);
    check_val("init_no_fcinc", n_fcinc - s_fcinc, 0);

    // Media lost after one record: attention, position retained.
    begin
      exp_t e;
      e.tag = "mol_drop"; e.lat = 31; e.drylow = 30; e.pip = 0; e.sdwn = 0;
      e.fcinc = 1; e.setidb = 1; e.unld = 0; e.pos = 16'd1; e.tm = 1'b0;
      sb.push_back(e);
    end
    issue(F_SPCFWD, 16'hFFF0);
    repeat (29) @(posedge clk); #1;
    mtMOLIN = 1'b0;
    finish_op(50);
    mtMOLIN = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
